// File: rtl/radar_pkg.sv
// Shared types and constants for the radar distance monitor.
// Channel-index width helper, stale display sentinel and alarm state encoding.
package radar_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ALARM = 1'b1
    } alarm_st_t;

    localparam int MAX_DISP_W = 64;

    // Shown in place of a distance when the selected radar has gone quiet.
    localparam logic [MAX_DISP_W-1:0] STALE_SENTINEL = '1;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/radar_ch_tracker.sv
// Per-radar distance latch, stale watchdog and hysteresis proximity alarm.
// Latency 1 cycle from valid to dist_q/alarm/stale; no backpressure, every strobe is accepted.
module radar_ch_tracker
    import radar_pkg::*;
#(
    parameter int DIST_W      = 20,
    parameter int ALARM_TH    = 35,
    parameter int HYST        = 3,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIST_W-1:0] data,
    input  logic              vld,
    output logic [DIST_W-1:0] dist_q,
    output logic              alarm,
    output logic              alarm_nxt,
    output logic              stale
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    // One extra bit so the release threshold cannot wrap.
    localparam logic [DIST_W:0] TH_SET = (DIST_W+1)'(ALARM_TH);
    localparam logic [DIST_W:0] TH_REL = TH_SET + (DIST_W+1)'(HYST);

    alarm_st_t        st_q;
    alarm_st_t        st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stale_d;
    logic [DIST_W:0]  data_ext;

    assign data_ext = {1'b0, data};

    always_comb begin
        cnt_d   = cnt_q;
        stale_d = stale;
        if (vld) begin
            cnt_d   = '0;
            stale_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d   = cnt_q + 1'b1;
            stale_d = (cnt_d == CNT_MAX);
        end
    end

    // A fresh sample drives the hysteresis; going stale forces the alarm off.
    always_comb begin
        st_d = st_q;
        if (vld) begin
            case (st_q)
                ST_CLEAR: if (data_ext <= TH_SET) st_d = ST_ALARM;
                ST_ALARM: if (data_ext > TH_REL)  st_d = ST_CLEAR;
                default:  st_d = ST_CLEAR;
            endcase
        end else if (stale_d) begin
            st_d = ST_CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= ST_CLEAR;
            cnt_q  <= '0;
            stale  <= 1'b0;
            dist_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            stale <= stale_d;
            if (vld) begin
                dist_q <= data;
            end
        end
    end

    assign alarm     = (st_q == ST_ALARM);
    assign alarm_nxt = (st_d == ST_ALARM);

endmodule

// File: rtl/radar_dist_monitor.sv
// N-channel radar distance monitor: per-channel alarms/stale flags plus manual or auto-scan display select.
// Latency: valid -> o_show_data 2 cycles, idx change -> display 1 cycle; no backpressure.
module radar_dist_monitor
    import radar_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIST_W      = 20,
    parameter int DISP_W      = 24,
    parameter int ALARM_TH    = 35,
    parameter int HYST        = 3,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int SCAN_CYC    = 100_000_000
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst_n,
    input  logic [NUM_CH*DIST_W-1:0]   i_dist_data,
    input  logic [NUM_CH-1:0]          i_dist_vld,
    input  logic                       i_key_next,
    input  logic                       i_mode_auto,
    output logic [DISP_W-1:0]          o_show_data,
    output logic [ch_w(NUM_CH)-1:0]    o_show_ch,
    output logic [NUM_CH-1:0]          o_alarm,
    output logic [NUM_CH-1:0]          o_stale,
    output logic                       o_any_alarm
);

    localparam int                CH_W      = ch_w(NUM_CH);
    localparam int                SCAN_W    = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    logic [DIST_W-1:0] dist_q [NUM_CH];
    logic [NUM_CH-1:0] alarm_nxt;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        radar_ch_tracker #(
            .DIST_W      (DIST_W),
            .ALARM_TH    (ALARM_TH),
            .HYST        (HYST),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_trk (
            .clk       (i_sys_clk),
            .rst_n     (i_sys_rst_n),
            .data      (i_dist_data[k*DIST_W +: DIST_W]),
            .vld       (i_dist_vld[k]),
            .dist_q    (dist_q[k]),
            .alarm     (o_alarm[k]),
            .alarm_nxt (alarm_nxt[k]),
            .stale     (o_stale[k])
        );
    end

    logic [CH_W-1:0]   idx_q;
    logic [CH_W-1:0]   idx_d;
    logic [CH_W-1:0]   idx_inc;
    logic [SCAN_W-1:0] scan_q;
    logic [SCAN_W-1:0] scan_d;

    // Key and timer expiry share one advance; manual mode pins the timer at 0,
    // which also gives the clear-on-mode-switch behaviour in both directions.
    always_comb begin
        idx_inc = (idx_q == CH_LAST) ? '0 : idx_q + 1'b1;
        idx_d   = idx_q;
        scan_d  = '0;
        if (i_mode_auto) begin
            if (i_key_next || (scan_q == SCAN_LAST)) begin
                idx_d = idx_inc;
            end else begin
                scan_d = scan_q + 1'b1;
            end
        end else if (i_key_next) begin
            idx_d = idx_inc;
        end
    end

    logic [DIST_W-1:0] sel_dist;
    logic              sel_stale;

    always_comb begin
        sel_dist  = '0;
        sel_stale = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == CH_W'(k)) begin
                sel_dist  = dist_q[k];
                sel_stale = o_stale[k];
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            idx_q       <= '0;
            scan_q      <= '0;
            o_show_ch   <= '0;
            o_show_data <= '0;
            o_any_alarm <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            scan_q      <= scan_d;
            o_show_ch   <= idx_q;
            o_show_data <= sel_stale ? STALE_SENTINEL[DISP_W-1:0] : DISP_W'(sel_dist);
            o_any_alarm <= |alarm_nxt;
        end
    end

endmodule

// File: tb/tb_radar_dist_monitor.sv
// Self-checking bench for radar_dist_monitor with NUM_CH=3, TIMEOUT_CYC=100, SCAN_CYC=20.
module tb_radar_dist_monitor;

    localparam int NUM_CH  = 3;
    localparam int DIST_W  = 20;
    localparam int DISP_W  = 24;
    localparam int TIMEOUT = 100;
    localparam int SCAN    = 20;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH*DIST_W-1:0] dist_data;
    logic [NUM_CH-1:0]        dist_vld;
    logic                     key_next;
    logic                     mode_auto;
    logic [DISP_W-1:0]        show_data;
    logic [1:0]               show_ch;
    logic [NUM_CH-1:0]        alarm;
    logic [NUM_CH-1:0]        stale;
    logic                     any_alarm;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    radar_dist_monitor #(
        .NUM_CH      (NUM_CH),
        .DIST_W      (DIST_W),
        .DISP_W      (DISP_W),
        .ALARM_TH    (35),
        .HYST        (3),
        .TIMEOUT_CYC (TIMEOUT),
        .SCAN_CYC    (SCAN)
    ) dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .i_dist_data (dist_data),
        .i_dist_vld  (dist_vld),
        .i_key_next  (key_next),
        .i_mode_auto (mode_auto),
        .o_show_data (show_data),
        .o_show_ch   (show_ch),
        .o_alarm     (alarm),
        .o_stale     (stale),
        .o_any_alarm (any_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int val);
        dist_data[ch*DIST_W +: DIST_W] = DIST_W'(val);
        dist_vld = '0;
        dist_vld[ch] = 1'b1;
        tick();
        dist_vld = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_tests++; if (show_data !== 24'h0) begin n_fail++; $display("FAIL reset_show_data got %h exp 0", show_data); end
        n_tests++; if (show_ch !== 2'd0) begin n_fail++; $display("FAIL reset_show_ch got %0d exp 0", show_ch); end
        n_tests++; if (alarm !== 3'b000) begin n_fail++; $display("FAIL reset_alarm got %b exp 000", alarm); end
        n_tests++; if (stale !== 3'b000) begin n_fail++; $display("FAIL reset_stale got %b exp 000", stale); end
        n_tests++; if (any_alarm !== 1'b0) begin n_fail++; $display("FAIL reset_any_alarm got %b exp 0", any_alarm); end
        rst_n = 1'b1;
    endtask

    task automatic test_hysteresis();
        int   vals [6];
        logic exps [6];
        logic [31:0] e;
        vals = '{40, 35, 37, 38, 39, 36};
        exps = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({31'd0, exps[i]});
            send(0, vals[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (alarm[0] !== e[0]) begin
                n_fail++; $display("FAIL hyst_alarm val=%0d got %b exp %b", vals[i], alarm[0], e[0]);
            end
            n_tests++;
            if (any_alarm !== e[0]) begin
                n_fail++; $display("FAIL hyst_any_alarm val=%0d got %b exp %b", vals[i], any_alarm, e[0]);
            end
        end
        exp_q.push_back(32'd36);
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (show_data !== e[DISP_W-1:0]) begin n_fail++; $display("FAIL hyst_show_data got %h exp %h", show_data, e[DISP_W-1:0]); end
    endtask

    task automatic test_stale();
        send(1, 10);
        n_tests++; if (alarm[1] !== 1'b1) begin n_fail++; $display("FAIL stale_pre_alarm got %b exp 1", alarm[1]); end
        repeat (TIMEOUT - 1) tick();
        n_tests++; if (stale[1] !== 1'b0) begin n_fail++; $display("FAIL stale_early got %b exp 0", stale[1]); end
        n_tests++; if (alarm[1] !== 1'b1) begin n_fail++; $display("FAIL stale_early_alarm got %b exp 1", alarm[1]); end
        tick();
        n_tests++; if (stale[1] !== 1'b1) begin n_fail++; $display("FAIL stale_entry got %b exp 1", stale[1]); end
        n_tests++; if (alarm[1] !== 1'b0) begin n_fail++; $display("FAIL stale_alarm_forced got %b exp 0", alarm[1]); end
        key_next = 1'b1;
        tick();
        key_next = 1'b0;
        tick();
        n_tests++; if (show_ch !== 2'd1) begin n_fail++; $display("FAIL stale_sel_ch got %0d exp 1", show_ch); end
        n_tests++; if (show_data !== 24'hFFFFFF) begin n_fail++; $display("FAIL stale_sentinel got %h exp ffffff", show_data); end
        send(1, 50);
        tick();
        n_tests++; if (stale[1] !== 1'b0) begin n_fail++; $display("FAIL stale_cleared got %b exp 0", stale[1]); end
        n_tests++; if (show_data !== 24'h000032) begin n_fail++; $display("FAIL stale_recover_data got %h exp 000032", show_data); end
    endtask

    task automatic test_valid_at_timeout();
        send(1, 60);
        repeat (TIMEOUT - 1) tick();
        send(1, 70);
        n_tests++; if (stale[1] !== 1'b0) begin n_fail++; $display("FAIL vt_valid_wins got %b exp 0", stale[1]); end
        repeat (TIMEOUT - 1) tick();
        n_tests++; if (stale[1] !== 1'b0) begin n_fail++; $display("FAIL vt_restart_early got %b exp 0", stale[1]); end
        tick();
        n_tests++; if (stale[1] !== 1'b1) begin n_fail++; $display("FAIL vt_restart_stale got %b exp 1", stale[1]); end
    endtask

    task automatic test_manual_wrap();
        logic [31:0] e_ch;
        logic [31:0] e_dat;
        int   chs  [3];
        int   dats [3];
        chs  = '{1, 2, 0};
        dats = '{200, 300, 100};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dist_data = {20'd300, 20'd200, 20'd100};
        dist_vld = 3'b111;
        tick();
        dist_vld = '0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(chs[i]));
            exp_q.push_back(32'(dats[i]));
            key_next = 1'b1;
            tick();
            key_next = 1'b0;
            tick();
            e_ch  = exp_q.pop_front();
            e_dat = exp_q.pop_front();
            n_tests++;
            if (show_ch !== e_ch[1:0]) begin n_fail++; $display("FAIL wrap_ch step=%0d got %0d exp %0d", i, show_ch, e_ch[1:0]); end
            n_tests++;
            if (show_data !== e_dat[DISP_W-1:0]) begin n_fail++; $display("FAIL wrap_data step=%0d got %0d exp %0d", i, show_data, e_dat[DISP_W-1:0]); end
        end
    endtask

    task automatic test_auto_scan();
        mode_auto = 1'b1;
        repeat (SCAN) tick();
        n_tests++; if (show_ch !== 2'd0) begin n_fail++; $display("FAIL auto_before_first got %0d exp 0", show_ch); end
        tick();
        n_tests++; if (show_ch !== 2'd1) begin n_fail++; $display("FAIL auto_first_adv got %0d exp 1", show_ch); end
        repeat (SCAN - 2) tick();
        key_next = 1'b1;
        tick();
        key_next = 1'b0;
        n_tests++; if (show_ch !== 2'd1) begin n_fail++; $display("FAIL auto_coincide_pre got %0d exp 1", show_ch); end
        tick();
        n_tests++; if (show_ch !== 2'd2) begin n_fail++; $display("FAIL auto_coincide_once got %0d exp 2", show_ch); end
        repeat (SCAN - 1) tick();
        n_tests++; if (show_ch !== 2'd2) begin n_fail++; $display("FAIL auto_next_early got %0d exp 2", show_ch); end
        tick();
        n_tests++; if (show_ch !== 2'd0) begin n_fail++; $display("FAIL auto_next_wrap got %0d exp 0", show_ch); end
    endtask

    task automatic test_reset_mid_scan();
        mode_auto = 1'b0;
        send(2, 5);
        key_next = 1'b1;
        repeat (2) tick();
        key_next = 1'b0;
        tick();
        n_tests++; if (show_ch !== 2'd2) begin n_fail++; $display("FAIL rmid_pre_ch got %0d exp 2", show_ch); end
        n_tests++; if (alarm[2] !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_alarm got %b exp 1", alarm[2]); end
        n_tests++; if (any_alarm !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_any got %b exp 1", any_alarm); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++; if (show_data !== 24'h0) begin n_fail++; $display("FAIL rmid_show_data got %h exp 0", show_data); end
        n_tests++; if (show_ch !== 2'd0) begin n_fail++; $display("FAIL rmid_show_ch got %0d exp 0", show_ch); end
        n_tests++; if (alarm !== 3'b000) begin n_fail++; $display("FAIL rmid_alarm got %b exp 000", alarm); end
        n_tests++; if (stale !== 3'b000) begin n_fail++; $display("FAIL rmid_stale got %b exp 000", stale); end
        n_tests++; if (any_alarm !== 1'b0) begin n_fail++; $display("FAIL rmid_any got %b exp 0", any_alarm); end
        tick();
        n_tests++; if (show_ch !== 2'd0) begin n_fail++; $display("FAIL rmid_idx_kept_zero got %0d exp 0", show_ch); end
        n_tests++; if (show_data !== 24'h0) begin n_fail++; $display("FAIL rmid_dist_cleared got %h exp 0", show_data); end
    endtask

    initial begin
        rst_n     = 1'b0;
        dist_data = '0;
        dist_vld  = '0;
        key_next  = 1'b0;
        mode_auto = 1'b0;
        test_reset();
        test_hysteresis();
        test_stale();
        test_valid_at_timeout();
        test_manual_wrap();
        test_auto_scan();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/radar_dist_monitor.md
Name: radar_dist_monitor

Overview:
- N-channel successor to the fixed two-radar distance select/alarm logic.
- Latches distance words from NUM_CH mmWave radar receivers and raises a per-channel proximity alarm with hysteresis.
- Flags a channel as stale when its radar stops reporting.
- Selects one channel for the 7-segment display, either manually (key pulse) or by timed auto-scan.
- Sits between the hmj_ld_top instances and seg_show / the alarm LEDs.

Parameters:
- NUM_CH, 2: number of radar channels (2..8).
- DIST_W, 20: distance word width.
- DISP_W, 24: display word width; must be >= DIST_W.
- ALARM_TH, 35: alarm asserts when distance <= ALARM_TH.
- HYST, 3: alarm deasserts when distance > ALARM_TH+HYST.
- TIMEOUT_CYC, 50_000_000: cycles without valid before a channel is stale (1 s at 50 MHz).
- SCAN_CYC, 100_000_000: auto-scan dwell per channel, in cycles.

Ports:
- i_sys_clk  in  1  system clock, 50 MHz.
- i_sys_rst_n  in  1  reset; synchronous, active-low.
- i_dist_data  in  NUM_CH*DIST_W  packed distances; channel k occupies bits [k*DIST_W +: DIST_W].
- i_dist_vld  in  NUM_CH  per-channel one-cycle valid strobe.
- i_key_next  in  1  debounced single-cycle pulse: advance the displayed channel.
- i_mode_auto  in  1  1 = timed auto-scan, 0 = manual selection.
- o_show_data  out  DISP_W  displayed distance, or the stale sentinel.
- o_show_ch  out  clog2(NUM_CH), min 1  index of the displayed channel.
- o_alarm  out  NUM_CH  per-channel proximity alarm.
- o_stale  out  NUM_CH  per-channel stale flag.
- o_any_alarm  out  1  OR of o_alarm.

Behaviour:
- Reset (synchronous, evaluated on the i_sys_clk edge while i_sys_rst_n=0):
  - All outputs are 0.
  - Latched distances, stale counters and scan timer are 0.
  - Channel index is 0.
  - Reset asserted mid-operation aborts everything on that edge; no partial state survives.
- Per channel k:
  - Data latch: if i_dist_vld[k]=1 at edge t, dist_q[k] <= the channel's slice, visible from t+1.
  - Alarm state machine, two states, updated on the same edge from the incoming slice:
    - CLEAR -> ALARM when data <= ALARM_TH.
    - ALARM -> CLEAR when data > ALARM_TH+HYST.
    - Otherwise hold. A sample with ALARM_TH < data <= ALARM_TH+HYST holds the current state.
  - Stale counter:
    - Valid clears the counter and clears stale.
    - Otherwise the counter increments, saturating at TIMEOUT_CYC.
    - Stale asserts on the cycle the counter reaches TIMEOUT_CYC.
    - Valid and saturation in the same cycle: valid wins.
  - Stale entry forces the alarm state to CLEAR. A stale channel never drives an alarm.
  - o_alarm[k] and o_stale[k] are registered and valid at t+1.
- Channel selection:
  - Manual mode: key pulse makes idx <= idx+1, wrapping NUM_CH-1 -> 0.
  - Auto mode:
    - scan_cnt counts to SCAN_CYC-1, then advances idx and restarts at 0.
    - A key pulse advances idx and restarts scan_cnt at 0.
    - Key pulse and timer expiry in the same cycle advance idx once only.
  - Switching modes: scan_cnt clears; idx is kept.
  - Outside auto mode scan_cnt is held at 0.
- Display path (registered):
  - o_show_ch <= idx.
  - o_show_data <= the stale sentinel (all ones) if the selected channel is stale; otherwise dist_q[idx] zero-extended to DISP_W.
  - Latency: valid at t gives o_show_data updated at t+2; an idx change gives an update 1 cycle later.
- o_any_alarm is registered: OR of the next-state alarms, so it is aligned with o_alarm.
- Arithmetic:
  - ALARM_TH+HYST is evaluated at DIST_W+1 bits, so it cannot overflow.
  - Stale counter width is clog2(TIMEOUT_CYC+1).
  - Scan counter width is clog2(SCAN_CYC).

Decomposition:
- Package radar_pkg:
  - Channel-index width function.
  - Stale sentinel constant.
  - Alarm state encoding: CLEAR=0, ALARM=1.
- Sub-module radar_ch_tracker, instantiated NUM_CH times by generate:
  - Per-channel data latch.
  - Stale counter.
  - Hysteresis alarm state machine.
- The top level holds the selection state machine, scan timer and display mux.

Test Plan (use NUM_CH=3, TIMEOUT_CYC=100, SCAN_CYC=20):
- Hysteresis: ch0 valid with 40 -> alarm 0; 35 -> o_alarm[0]=1 at t+1; 37 -> stays 1; 38 -> stays 1; 39 -> 0.
- Stale: ch1 valid 10 (alarm=1), then no valid for 100 cycles -> o_stale[1]=1 and o_alarm[1]=0 on that cycle. Selecting ch1 shows 0xFFFFFF. A later valid of 50 clears stale and shows 0x000032.
- Manual wrap: 3 key pulses -> o_show_ch 1,2,0. o_show_data follows dist_q of the new channel 1 cycle after each pulse.
- Auto scan: mode=1 -> o_show_ch advances every 20 cycles. Key and timer expiry in the same cycle -> advances by exactly 1, and the next advance comes 20 cycles later.
- Simultaneous valid and timeout: valid arrives on the saturation cycle -> o_stale stays 0 and the counter restarts.
- Reset mid-scan: assert i_sys_rst_n=0 for 1 edge during alarm and idx=2 -> all outputs 0 and idx=0 on the following cycle.
